// File: rtl/result_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : result_pipe_pkg
// Brief    : Shared CPU widths, zero-register constant and MEM FSM encoding.
// Revision : 1.0  initial release
// ============================================================================
package result_pipe_pkg;

    localparam int c_REG_W  = 5;
    localparam int c_DATA_W = 32;

    localparam logic [c_REG_W-1:0] c_ZERO_REG = '0;

    typedef enum logic [0:0] {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_t;

endpackage : result_pipe_pkg
`default_nettype wire

// File: rtl/result_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : result_pipe_stage
// Brief    : One stall-able valid/we/lw/dst/data pipeline register.
// Revision : 1.0  initial release
// ============================================================================
module result_pipe_stage
    import result_pipe_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_hold,
    input  logic                i_valid,
    input  logic                i_we,
    input  logic                i_lw,
    input  logic [c_REG_W-1:0]  i_dst,
    input  logic [c_DATA_W-1:0] i_data,
    output logic                o_valid,
    output logic                o_we,
    output logic                o_lw,
    output logic [c_REG_W-1:0]  o_dst,
    output logic [c_DATA_W-1:0] o_data
);

    logic                r_valid;
    logic                r_we;
    logic                r_lw;
    logic [c_REG_W-1:0]  r_dst;
    logic [c_DATA_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_lw    <= 1'b0;
            r_dst   <= c_ZERO_REG;
            r_data  <= '0;
        end else if (!i_hold) begin
            r_valid <= i_valid;
            r_we    <= i_we;
            r_lw    <= i_lw;
            r_dst   <= i_dst;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_we    = r_we;
    assign o_lw    = r_lw;
    assign o_dst   = r_dst;
    assign o_data  = r_data;

endmodule : result_pipe_stage
`default_nettype wire

// File: rtl/result_pipe.sv
`default_nettype none
// ============================================================================
// Module   : result_pipe
// Brief    : EX->MEM->WB result pipeline with load handshake and forwarding
//            taps. Define RESULT_PIPE_WB_TAP_EN to add the WB forwarding tap.
// Revision : 1.0  initial release
// ============================================================================
module result_pipe
    import result_pipe_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    // EX load flag is ex_load because ex_lw is the forwarding output
    input  logic                ex_valid,
    input  logic                ex_we,
    input  logic                ex_load,
    input  logic [c_REG_W-1:0]  ex_dst,
    input  logic [c_DATA_W-1:0] ex_res,
    input  logic                ex_flush,
    output logic                dmem_req,
    output logic [c_DATA_W-1:0] dmem_addr,
    input  logic [c_DATA_W-1:0] dmem_rdata,
    input  logic                dmem_ack,
    output logic [c_REG_W-1:0]  ex_rf_dst,
    output logic                ex_lw,
    output logic [c_DATA_W-1:0] data_ex,
    output logic [c_REG_W-1:0]  mem_rf_dst,
    output logic                mem_lw,
    output logic [c_DATA_W-1:0] data_mem,
    output logic                mem_stall,
    output logic                rf_we,
    output logic [c_REG_W-1:0]  rf_waddr,
    output logic [c_DATA_W-1:0] rf_wdata
`ifdef RESULT_PIPE_WB_TAP_EN
    ,
    output logic [c_REG_W-1:0]  wb_rf_dst,
    output logic [c_DATA_W-1:0] data_wb
`endif
);

    mem_state_t          r_state;

    logic                w_ex_take;
    logic                w_ex_is_load;
    logic                w_stall;
    logic                w_waiting;

    logic                w_mem_valid;
    logic                w_mem_we;
    logic                w_mem_lw;
    logic [c_REG_W-1:0]  w_mem_dst;
    logic [c_DATA_W-1:0] w_mem_data;

    logic                w_wb_in_valid;
    logic [c_DATA_W-1:0] w_wb_in_data;
    logic                w_wb_valid;
    logic                w_wb_we;
    logic                w_wb_lw_unused;
    logic [c_REG_W-1:0]  w_wb_dst;
    logic [c_DATA_W-1:0] w_wb_data;

    // EX forwarding tap
    assign ex_rf_dst = (ex_valid && ex_we && (ex_dst != c_ZERO_REG)) ? ex_dst : c_ZERO_REG;
    assign ex_lw     = ex_valid && ex_load && (ex_rf_dst != c_ZERO_REG);
    assign data_ex   = ex_res;

    assign w_ex_take    = ex_valid && !ex_flush;
    assign w_ex_is_load = w_ex_take && ex_load;

    assign w_waiting = (r_state == M_WAIT);
    assign w_stall   = w_waiting && !dmem_ack;
    assign mem_stall = w_stall;

    result_pipe_stage u_mem_stage (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (w_stall),
        .i_valid (w_ex_take),
        .i_we    (ex_we),
        .i_lw    (ex_load),
        .i_dst   (ex_dst),
        .i_data  (ex_res),
        .o_valid (w_mem_valid),
        .o_we    (w_mem_we),
        .o_lw    (w_mem_lw),
        .o_dst   (w_mem_dst),
        .o_data  (w_mem_data)
    );

    // The FSM sits in M_WAIT exactly while a load occupies MEM, so the
    // next state is decided by whatever enters MEM on an unstalled edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= M_IDLE;
        end else if (!w_stall) begin
            r_state <= w_ex_is_load ? M_WAIT : M_IDLE;
        end
    end

    assign dmem_req  = w_waiting;
    assign dmem_addr = w_mem_data;

    // MEM forwarding tap
    assign mem_rf_dst = (w_mem_valid && w_mem_we && (w_mem_dst != c_ZERO_REG)) ? w_mem_dst : c_ZERO_REG;
    assign data_mem   = w_mem_data;
    assign mem_lw     = w_stall && w_mem_valid && w_mem_lw && (mem_rf_dst != c_ZERO_REG);

    assign w_wb_in_valid = w_mem_valid && !w_stall;
    assign w_wb_in_data  = w_waiting ? dmem_rdata : w_mem_data;

    result_pipe_stage u_wb_stage (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (1'b0),
        .i_valid (w_wb_in_valid),
        .i_we    (w_mem_we),
        .i_lw    (w_mem_lw),
        .i_dst   (w_mem_dst),
        .i_data  (w_wb_in_data),
        .o_valid (w_wb_valid),
        .o_we    (w_wb_we),
        .o_lw    (w_wb_lw_unused),
        .o_dst   (w_wb_dst),
        .o_data  (w_wb_data)
    );

    assign rf_we    = w_wb_valid && w_wb_we && (w_wb_dst != c_ZERO_REG);
    assign rf_waddr = w_wb_dst;
    assign rf_wdata = w_wb_data;

`ifdef RESULT_PIPE_WB_TAP_EN
    assign wb_rf_dst = rf_we ? w_wb_dst : c_ZERO_REG;
    assign data_wb   = w_wb_data;
`endif

endmodule : result_pipe
`default_nettype wire

// File: tb/tb_result_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_pipe
// Brief    : Directed self-checking bench for result_pipe.
// Revision : 1.0  initial release
// ============================================================================
module tb_result_pipe;
    import result_pipe_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                ex_valid, ex_we, ex_load, ex_flush;
    logic [c_REG_W-1:0]  ex_dst;
    logic [c_DATA_W-1:0] ex_res;
    logic                dmem_req;
    logic [c_DATA_W-1:0] dmem_addr;
    logic [c_DATA_W-1:0] dmem_rdata;
    logic                dmem_ack;
    logic [c_REG_W-1:0]  ex_rf_dst, mem_rf_dst, rf_waddr;
    logic                ex_lw, mem_lw, mem_stall, rf_we;
    logic [c_DATA_W-1:0] data_ex, data_mem, rf_wdata;
`ifdef RESULT_PIPE_WB_TAP_EN
    logic [c_REG_W-1:0]  wb_rf_dst;
    logic [c_DATA_W-1:0] data_wb;
`endif

    int n_checks = 0;
    int n_err    = 0;

    result_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_we      (ex_we),
        .ex_load    (ex_load),
        .ex_dst     (ex_dst),
        .ex_res     (ex_res),
        .ex_flush   (ex_flush),
        .dmem_req   (dmem_req),
        .dmem_addr  (dmem_addr),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .ex_rf_dst  (ex_rf_dst),
        .ex_lw      (ex_lw),
        .data_ex    (data_ex),
        .mem_rf_dst (mem_rf_dst),
        .mem_lw     (mem_lw),
        .data_mem   (data_mem),
        .mem_stall  (mem_stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
`ifdef RESULT_PIPE_WB_TAP_EN
        ,
        .wb_rf_dst  (wb_rf_dst),
        .data_wb    (data_wb)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic ld,
                         input logic [4:0] dst, input logic [31:0] res, input logic fl);
        ex_valid = v;
        ex_we    = we;
        ex_load  = ld;
        ex_dst   = dst;
        ex_res   = res;
        ex_flush = fl;
    endtask

    initial begin
        rst        = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_rf_we",      rf_we,      32'd0);
        chk("reset_rf_waddr",   rf_waddr,   32'd0);
        chk("reset_rf_wdata",   rf_wdata,   32'd0);
        chk("reset_dmem_req",   dmem_req,   32'd0);
        chk("reset_mem_stall",  mem_stall,  32'd0);
        chk("reset_mem_rf_dst", mem_rf_dst, 32'd0);
        chk("reset_data_mem",   data_mem,   32'd0);

        // ALU op r5 <= 0x1234
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h1234, 1'b0);
        #1;
        chk("alu_ex_rf_dst", ex_rf_dst, 32'd5);
        chk("alu_data_ex",   data_ex,   32'h1234);
        chk("alu_ex_lw",     ex_lw,     32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        chk("alu_mem_rf_dst", mem_rf_dst, 32'd5);
        chk("alu_data_mem",   data_mem,   32'h1234);
        chk("alu_c1_rf_we",   rf_we,      32'd0);
        tick();
        #1;
        chk("alu_rf_we",    rf_we,    32'd1);
        chk("alu_rf_waddr", rf_waddr, 32'd5);
        chk("alu_rf_wdata", rf_wdata, 32'h1234);

        // write to r0
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 32'h55, 1'b0);
        #1;
        chk("r0_ex_rf_dst", ex_rf_dst, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        chk("r0_mem_rf_dst", mem_rf_dst, 32'd0);
        tick();
        #1;
        chk("r0_rf_we", rf_we, 32'd0);

        // flushed ALU op
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h77, 1'b1);
        #1;
        chk("flush_ex_rf_dst", ex_rf_dst, 32'd7);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        chk("flush_mem_rf_dst", mem_rf_dst, 32'd0);
        tick();
        #1;
        chk("flush_rf_we", rf_we, 32'd0);

        // load r8 from 0x40, ack on 4th cycle in MEM; ALU r3 waits in EX
        tick();
        drive(1'b1, 1'b1, 1'b1, 5'd8, 32'h40, 1'b0);
        #1;
        chk("ld_ex_lw",     ex_lw,     32'd1);
        chk("ld_ex_stall",  mem_stall, 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h33, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            ex_flush = (i == 1);
            #1;
            chk("ld_wait_mem_lw",    mem_lw,    32'd1);
            chk("ld_wait_stall",     mem_stall, 32'd1);
            chk("ld_wait_dmem_req",  dmem_req,  32'd1);
            chk("ld_wait_dmem_addr", dmem_addr, 32'h40);
            chk("ld_wait_rf_we",     rf_we,     32'd0);
        end
        tick();
        ex_flush   = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE;
        #1;
        chk("ld_ack_stall",    mem_stall, 32'd0);
        chk("ld_ack_mem_lw",   mem_lw,    32'd0);
        chk("ld_ack_dmem_req", dmem_req,  32'd1);
        chk("ld_ack_rf_we",    rf_we,     32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        #1;
        chk("ld_wb_rf_we",      rf_we,      32'd1);
        chk("ld_wb_rf_waddr",   rf_waddr,   32'd8);
        chk("ld_wb_rf_wdata",   rf_wdata,   32'hCAFE);
        chk("held_mem_rf_dst",  mem_rf_dst, 32'd3);
        chk("held_data_mem",    data_mem,   32'h33);
        chk("ld_done_dmem_req", dmem_req,   32'd0);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hBAD;
        #1;
        chk("idle_ack_stall", mem_stall, 32'd0);
        chk("held_rf_we",     rf_we,     32'd1);
        chk("held_rf_waddr",  rf_waddr,  32'd3);
        chk("held_rf_wdata",  rf_wdata,  32'h33);
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("idle_ack_rf_we", rf_we, 32'd0);

        // back-to-back loads r9 @0x100, r10 @0x104, each acked at once
        tick();
        drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h100, 1'b0);
        #1;
        tick();
        drive(1'b1, 1'b1, 1'b1, 5'd10, 32'h104, 1'b0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h9999;
        #1;
        chk("b2b_a_stall",     mem_stall, 32'd0);
        chk("b2b_a_dmem_req",  dmem_req,  32'd1);
        chk("b2b_a_dmem_addr", dmem_addr, 32'h100);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        dmem_rdata = 32'hAAAA;
        #1;
        chk("b2b_b_dmem_req",  dmem_req,  32'd1);
        chk("b2b_b_dmem_addr", dmem_addr, 32'h104);
        chk("b2b_b_stall",     mem_stall, 32'd0);
        chk("b2b_a_rf_we",     rf_we,     32'd1);
        chk("b2b_a_rf_waddr",  rf_waddr,  32'd9);
        chk("b2b_a_rf_wdata",  rf_wdata,  32'h9999);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        #1;
        chk("b2b_b_rf_we",     rf_we,     32'd1);
        chk("b2b_b_rf_waddr",  rf_waddr,  32'd10);
        chk("b2b_b_rf_wdata",  rf_wdata,  32'hAAAA);
        chk("b2b_end_dmem_req", dmem_req, 32'd0);

        // reset while waiting on load r11, then late ack
        tick();
        drive(1'b1, 1'b1, 1'b1, 5'd11, 32'h200, 1'b0);
        #1;
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstw_pre_dmem_req", dmem_req, 32'd1);
        tick();
        rst        = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD;
        #1;
        chk("rstw_dmem_req",  dmem_req,  32'd0);
        chk("rstw_stall",     mem_stall, 32'd0);
        chk("rstw_mem_lw",    mem_lw,    32'd0);
        chk("rstw_rf_we",     rf_we,     32'd0);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        #1;
        chk("rstw_late_rf_we",    rf_we,    32'd0);
        chk("rstw_late_dmem_req", dmem_req, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_result_pipe
`default_nettype wire
